// File: rtl/imem_ctrl.sv
// Instruction memory port owner: clears the array after reset, then arbitrates fetch reads vs loader writes.
// Latency: fetch_inst/fetch_valid/fetch_err one cycle after the request edge; load_done one cycle after the last write.
// Backpressure: fetch_stall while clearing/loading; load_ready only in LOAD, a word is taken on any load_valid cycle.
module imem_ctrl #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic [DATA_W-1:0] fetch_inst,
    output logic              fetch_valid,
    output logic              fetch_err,
    output logic              fetch_stall,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    localparam state_t              RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
    localparam logic [ADDR_W-1:0]   LAST_ADDR = {ADDR_W{1'b1}};

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [ADDR_W-1:0]   ld_cnt_q;
    logic [DATA_W-1:0]   fetch_inst_q;
    logic                fetch_valid_q;
    logic                fetch_err_q;
    logic                load_done_q;
    logic                pc_bad;
    logic [ADDR_W-1:0]   pc_word;

    assign pc_word = fetch_pc[ADDR_W+1:2];
    assign pc_bad  = (fetch_pc[1:0] != 2'b00) || (fetch_pc[31:ADDR_W+2] != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RST_STATE;
            clr_cnt_q     <= '0;
            ld_cnt_q      <= '0;
            fetch_inst_q  <= '0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    fetch_valid_q <= 1'b0;
                    fetch_err_q   <= 1'b0;
                    clr_cnt_q     <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // The fetch presented alongside load_start is still served this edge.
                    if (fetch_req) begin
                        fetch_valid_q <= 1'b1;
                        fetch_err_q   <= pc_bad;
                        fetch_inst_q  <= pc_bad ? '0 : mem_rdata;
                    end else begin
                        fetch_valid_q <= 1'b0;
                        fetch_err_q   <= 1'b0;
                    end
                    if (load_start) begin
                        state_q  <= S_LOAD;
                        ld_cnt_q <= '0;
                    end
                end
                S_LOAD: begin
                    fetch_valid_q <= 1'b0;
                    fetch_err_q   <= 1'b0;
                    if (load_valid) begin
                        ld_cnt_q <= ld_cnt_q + 1'b1;
                        // Writing the top word ends the burst rather than wrapping onto word 0.
                        if (load_last || (ld_cnt_q == LAST_ADDR)) begin
                            state_q     <= S_RUN;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= RST_STATE;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr  = pc_word;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_addr = clr_cnt_q;
                mem_we   = 1'b1;
            end
            S_LOAD: begin
                mem_addr  = ld_cnt_q;
                mem_wdata = load_data;
                mem_we    = load_valid;
            end
            default: begin
                mem_addr = pc_word;
            end
        endcase
    end

    assign busy        = (state_q != S_RUN);
    assign fetch_stall = fetch_req & busy;
    assign load_ready  = (state_q == S_LOAD);
    assign fetch_inst  = fetch_inst_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_err   = fetch_err_q;
    assign load_done   = load_done_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: behavioural array model, vector table for RUN/LOAD, directed clear/wrap/reset sequences.
module tb_imem_ctrl;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic [DW-1:0] fetch_inst;
    logic          fetch_valid;
    logic          fetch_err;
    logic          fetch_stall;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          load_done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic          pre_fill;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_dat;
    logic [DW-1:0] mem [0:DEPTH-1];

    int n_cmp = 0;
    int n_bad = 0;

    imem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_pc   (fetch_pc),
        .fetch_inst (fetch_inst),
        .fetch_valid(fetch_valid),
        .fetch_err  (fetch_err),
        .fetch_stall(fetch_stall),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_fill) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= 32'hA5A5_0000 | k;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_dat;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        ls;
        logic        lv;
        logic [31:0] ld;
        logic        ll;
        logic        e_stall;
        logic        e_ready;
        logic        e_busy;
        logic        e_we;
        logic [6:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_err;
        logic        e_done;
    } vec_t;

    vec_t vt [11];

    initial begin
        int cnt;
        int nz;
        //        req pc      ls lv ld     ll  stl rdy bsy we addr wdata  vld inst          err done
        vt[0]  = '{1, 32'h14, 0, 0, 32'h0,  0,  0,  0,  0, 0, 5,   32'h0,  1, 32'hDEADBEEF, 0, 0};
        vt[1]  = '{0, 32'h14, 0, 0, 32'h0,  0,  0,  0,  0, 0, 5,   32'h0,  0, 32'hDEADBEEF, 0, 0};
        vt[2]  = '{1, 32'h6,  0, 0, 32'h0,  0,  0,  0,  0, 0, 1,   32'h0,  1, 32'h0,        1, 0};
        vt[3]  = '{1, 32'h200,0, 0, 32'h0,  0,  0,  0,  0, 0, 0,   32'h0,  1, 32'h0,        1, 0};
        vt[4]  = '{1, 32'h14, 1, 0, 32'h0,  0,  0,  0,  0, 0, 5,   32'h0,  1, 32'hDEADBEEF, 0, 0};
        vt[5]  = '{1, 32'h14, 0, 1, 32'h11, 0,  1,  1,  1, 1, 0,   32'h11, 0, 32'hDEADBEEF, 0, 0};
        vt[6]  = '{0, 32'h14, 0, 0, 32'h0,  0,  0,  1,  1, 0, 1,   32'h0,  0, 32'hDEADBEEF, 0, 0};
        vt[7]  = '{0, 32'h14, 0, 1, 32'h22, 0,  0,  1,  1, 1, 1,   32'h22, 0, 32'hDEADBEEF, 0, 0};
        vt[8]  = '{0, 32'h14, 0, 0, 32'h99, 1,  0,  1,  1, 0, 2,   32'h0,  0, 32'hDEADBEEF, 0, 0};
        vt[9]  = '{0, 32'h14, 0, 1, 32'h33, 1,  0,  1,  1, 1, 2,   32'h33, 0, 32'hDEADBEEF, 0, 1};
        vt[10] = '{1, 32'h8,  0, 0, 32'h0,  0,  0,  0,  0, 0, 2,   32'h0,  1, 32'h33,       0, 0};

        rst = 1'b1; fetch_req = 0; fetch_pc = '0; load_start = 0; load_valid = 0;
        load_data = '0; load_last = 0; pre_fill = 0; pre_we = 0; pre_addr = '0; pre_dat = '0;
        #1 rst = 1'b0;
        pre_fill = 1'b1;
        @(posedge clk); #1 pre_fill = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_valid", fetch_valid, 0);
        chk("rst_inst", fetch_inst, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_done", load_done, 0);
        chk("rst_busy", busy, 1);
        chk("rst_we", mem_we, 1);
        chk("rst_addr", mem_addr, 0);

        // Clear sequence with fetch requests sprinkled in
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fetch_req = (i % 2 == 1);
            #1;
            chk($sformatf("clr_addr%0d", i), mem_addr, i);
            chk("clr_we", mem_we, 1);
            chk("clr_wdata", mem_wdata, 0);
            chk("clr_busy", busy, 1);
            chk("clr_stall", fetch_stall, (i % 2 == 1));
            @(posedge clk); #1;
            chk("clr_valid", fetch_valid, 0);
            @(negedge clk);
        end
        fetch_req = 0; #1;
        chk("clr_end_busy", busy, 0);
        chk("clr_end_we", mem_we, 0);
        nz = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== '0) nz++;
        chk("clr_nonzero_words", nz, 0);

        pre_we = 1'b1; pre_addr = 7'd5; pre_dat = 32'hDEADBEEF;
        @(posedge clk); #1 pre_we = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            fetch_req = vt[i].req; fetch_pc = vt[i].pc; load_start = vt[i].ls;
            load_valid = vt[i].lv; load_data = vt[i].ld; load_last = vt[i].ll;
            #1;
            chk($sformatf("v%0d_stall", i), fetch_stall, vt[i].e_stall);
            chk($sformatf("v%0d_ready", i), load_ready, vt[i].e_ready);
            chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
            chk($sformatf("v%0d_we", i), mem_we, vt[i].e_we);
            chk($sformatf("v%0d_addr", i), mem_addr, vt[i].e_addr);
            if (vt[i].e_we) chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].e_wdata);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), fetch_valid, vt[i].e_valid);
            chk($sformatf("v%0d_inst", i), fetch_inst, vt[i].e_inst);
            chk($sformatf("v%0d_err", i), fetch_err, vt[i].e_err);
            chk($sformatf("v%0d_done", i), load_done, vt[i].e_done);
            @(negedge clk);
        end
        fetch_req = 0; load_valid = 0; load_last = 0;
        chk("burst_mem0", mem[0], 32'h11);
        chk("burst_mem1", mem[1], 32'h22);
        chk("burst_mem2", mem[2], 32'h33);
        chk("burst_mem3", mem[3], 32'h0);

        // Full-depth burst without load_last
        load_start = 1; @(posedge clk); @(negedge clk); load_start = 0;
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1; load_data = 32'h1000 + i; #1;
            chk($sformatf("wrap_addr%0d", i), mem_addr, i);
            chk("wrap_we", mem_we, 1);
            @(posedge clk); #1;
            chk($sformatf("wrap_done%0d", i), load_done, (i == DEPTH - 1));
            @(negedge clk);
        end
        load_data = 32'hBAD; #1;
        chk("wrap_busy", busy, 0);
        chk("wrap_we_after", mem_we, 0);
        @(posedge clk); #1;
        chk("wrap_done_clr", load_done, 0);
        @(negedge clk); load_valid = 0;
        chk("wrap_mem0", mem[0], 32'h1000);
        chk("wrap_mem127", mem[127], 32'h107F);

        // Reset in the middle of a burst
        fetch_req = 1; fetch_pc = 32'h14;
        @(posedge clk); #1;
        chk("pre_rst_inst", fetch_inst, 32'h1005);
        @(negedge clk); fetch_req = 0; load_start = 1;
        @(posedge clk); @(negedge clk); load_start = 0;
        load_valid = 1; load_data = 32'hAA;
        @(posedge clk); @(negedge clk); load_data = 32'hBB;
        @(posedge clk); @(negedge clk); load_data = 32'hCC; load_last = 1;
        rst = 1'b0; #1;
        chk("mid_inst", fetch_inst, 0);
        chk("mid_valid", fetch_valid, 0);
        chk("mid_err", fetch_err, 0);
        chk("mid_done", load_done, 0);
        chk("mid_busy", busy, 1);
        chk("mid_addr", mem_addr, 0);
        chk("mid_we", mem_we, 1);
        load_valid = 0; load_last = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_hold_done", load_done, 0);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rclr_addr%0d", i), mem_addr, i);
            @(posedge clk); #1;
            chk("rclr_done", load_done, 0);
            @(negedge clk);
        end
        cnt = 3;
        while (busy && cnt < 300) begin
            @(posedge clk); @(negedge clk);
            cnt++;
        end
        chk("rclr_cycles", cnt, DEPTH);
        chk("rclr_mem0", mem[0], 0);
        chk("rclr_mem1", mem[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
